// File: rtl/fft_sram_pkg.sv
// Shared types and default widths for the FFT sample SRAM arbiter.
package fft_sram_pkg;

  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    FE   = 2'd1,
    RB   = 2'd2
  } rd_tag_t;

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-return tag delay line: carries who issued each read until its data
// arrives on the SRAM read bus. Flush clears every in-flight tag at once.
module sram_rd_pipe
  import fft_sram_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic    clk,
  input  logic    flush,
  input  rd_tag_t push_tag,
  output rd_tag_t out_tag
);

  rd_tag_t stage [0:RD_LAT];

  // Shift tags one stage per cycle; flush drops anything in flight immediately.
  always_ff @(posedge clk or posedge flush) begin
    if (flush) begin
      for (int i = 0; i <= RD_LAT; i++) stage[i] <= NONE;
    end else begin
      stage[0] <= push_tag;
      for (int i = 1; i <= RD_LAT; i++) stage[i] <= stage[i-1];
    end
  end

  assign out_tag = stage[RD_LAT];

endmodule

// File: rtl/fft_sram_arbiter.sv
// Arbiter for the single-port FFT sample SRAM. A mode FSM hands the memory
// to the loader/read-back pair (IDLE, DONE) or to the FFT engine (RUN).
// Grants are combinational; SRAM commands and read returns are registered.
module fft_sram_arbiter
  import fft_sram_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  input  logic              fft_start,
  input  logic              fe_req,
  input  logic              fe_we,
  input  logic [ADDR_W-1:0] fe_addr,
  input  logic [DATA_W-1:0] fe_wdata,
  input  logic              fe_done,
  output logic              fe_gnt,
  output logic              fe_rvalid,
  output logic [DATA_W-1:0] fe_rdata,
  input  logic              rb_req,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic              rb_gnt,
  output logic              rb_rvalid,
  output logic [DATA_W-1:0] rb_rdata,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              busy,
  output logic              done,
  output logic              ld_drop
);

  arb_state_t state, next_state;
  logic       in_run;
  logic       ld_perf;
  logic       ld_discard;
  logic       start_acc;
  rd_tag_t    push_tag;
  rd_tag_t    out_tag;

  // Grants from current owner; the loader cannot stall so it beats read-back.
  always_comb begin
    in_run     = (state == RUN);
    ld_perf    = ~rst & ~in_run & ld_we;
    ld_discard = ~rst & in_run & ld_we;
    start_acc  = ~rst & ~in_run & fft_start;
    fe_gnt     = ~rst & in_run & fe_req;
    rb_gnt     = ~rst & ~in_run & rb_req & ~ld_we;
    push_tag   = NONE;
    if (fe_gnt && !fe_we) push_tag = FE;
    else if (rb_gnt)      push_tag = RB;
  end

  // Mode transitions; a start from DONE outranks the reload back to IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (fft_start) next_state = RUN;
      RUN:  if (fe_done) next_state = DONE;
      DONE: begin
        if (fft_start)  next_state = RUN;
        else if (ld_we) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // State register with registered busy/done decodes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state == RUN);
      done  <= (next_state == DONE);
    end
  end

  // SRAM command register; address and write data hold when nothing is granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sram_en    <= 1'b0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
    end else begin
      sram_en <= ld_perf | fe_gnt | rb_gnt;
      sram_we <= 1'b0;
      if (ld_perf) begin
        sram_we    <= 1'b1;
        sram_addr  <= ld_addr;
        sram_wdata <= ld_wdata;
      end else if (fe_gnt) begin
        sram_we   <= fe_we;
        sram_addr <= fe_addr;
        if (fe_we) sram_wdata <= fe_wdata;
      end else if (rb_gnt) begin
        sram_addr <= rb_addr;
      end
    end
  end

  // Sticky drop flag: set by a loader write during RUN, cleared on an accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             ld_drop <= 1'b0;
    else if (ld_discard) ld_drop <= 1'b1;
    else if (start_acc)  ld_drop <= 1'b0;
  end

  sram_rd_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk      (clk),
    .flush    (rst),
    .push_tag (push_tag),
    .out_tag  (out_tag)
  );

  // Steer returning SRAM data to whichever requester issued the read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fe_rvalid <= 1'b0;
      fe_rdata  <= '0;
      rb_rvalid <= 1'b0;
      rb_rdata  <= '0;
    end else begin
      fe_rvalid <= (out_tag == FE);
      rb_rvalid <= (out_tag == RB);
      if (out_tag == FE) fe_rdata <= sram_rdata;
      if (out_tag == RB) rb_rdata <= sram_rdata;
    end
  end

endmodule
